// File: rtl/dtree_pkg.sv
// Shared types and widths for the decision-tree feeder and dtree core.
// Widths of level/path match the dtree result bus.
package dtree_pkg;
  localparam int IN_WIDTH = 10;
  localparam int FEATURES = 3;
  localparam int LVL_W = 2;
  localparam int PATH_W = 2;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    GAP,
    DONE
  } state_t;

  typedef struct packed {
    logic [LVL_W-1:0] level;
    logic [PATH_W-1:0] path;
    logic err;
  } dt_res_t;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dtree_feature_buf.sv
// Feature vector register file: one write port, one async read port.
// Storage is not reset; contents are always rewritten before use.
module dtree_feature_buf #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 10,
  parameter int AW = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dtree_feeder.sv
// Buffers one feature vector and replays it into dtree until it answers
// or the pass budget runs out; reports a registered result pulse.
module dtree_feeder #(
  parameter int FEATURES = dtree_pkg::FEATURES,
  parameter int IN_WIDTH = dtree_pkg::IN_WIDTH,
  parameter int MAX_PASSES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IN_WIDTH-1:0]          in_sample,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [IN_WIDTH-1:0]          dt_sample,
  output logic                         dt_valid,
  input  logic                         dt_ready,
  input  logic [dtree_pkg::LVL_W-1:0]  dt_level,
  input  logic [dtree_pkg::PATH_W-1:0] dt_path,
  input  logic                         dt_out_valid,
  output logic [dtree_pkg::LVL_W-1:0]  res_level,
  output logic [dtree_pkg::PATH_W-1:0] res_path,
  output logic                         res_valid,
  output logic                         res_err,
  output logic [7:0]                   drop_count
);
  import dtree_pkg::*;

  localparam int IW = cw(FEATURES);
  localparam int PW = cw(MAX_PASSES + 1);
  localparam logic [IW-1:0] LAST = IW'(FEATURES - 1);
  localparam logic [PW-1:0] PLAST = PW'(MAX_PASSES - 1);

  state_t state_q, state_d;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [PW-1:0] pass_cnt;
  logic [IN_WIDTH-1:0] rd_data;
  logic rdy_q;
  logic ld_beat, dt_beat;
  logic last_wr, last_rd;
  logic hit, abort;
  dt_res_t res_q;

  assign ld_beat = in_valid && rdy_q;
  assign dt_beat = dt_valid && dt_ready;
  assign last_wr = wr_idx == LAST;
  assign last_rd = rd_idx == LAST;
  assign hit = dt_out_valid &&
               (state_q == STREAM || state_q == GAP);
  assign abort = state_q == STREAM && !dt_out_valid &&
                 dt_beat && last_rd && pass_cnt == PLAST;

  dtree_feature_buf #(
    .DEPTH(FEATURES),
    .WIDTH(IN_WIDTH),
    .AW(IW)
  ) u_buf (
    .clk(clk),
    .we(ld_beat),
    .waddr(wr_idx),
    .wdata(in_sample),
    .raddr(rd_idx),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= LOAD;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:
        if (ld_beat && last_wr) state_d = STREAM;
      STREAM:
        if (dt_out_valid) state_d = DONE;
        else if (dt_beat && last_rd)
          state_d = (pass_cnt == PLAST) ? DONE : GAP;
      GAP:
        state_d = dt_out_valid ? DONE : STREAM;
      DONE:
        state_d = LOAD;
      default:
        state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready = rdy_q;
    dt_valid = state_q == STREAM;
    dt_sample = dt_valid ? rd_data : '0;
  end

  // in_ready comes from a flop so it stays low for the reset cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdy_q <= 1'b0;
      wr_idx <= '0;
      rd_idx <= '0;
      pass_cnt <= '0;
      drop_count <= '0;
    end else begin
      rdy_q <= state_d == LOAD;
      if (in_valid && !rdy_q && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      if (ld_beat)
        wr_idx <= last_wr ? '0 : wr_idx + 1'b1;
      if (ld_beat && last_wr) begin
        rd_idx <= '0;
        pass_cnt <= '0;
      end else if (hit) begin
        rd_idx <= '0;
      end else if (state_q == STREAM && dt_beat) begin
        rd_idx <= last_rd ? '0 : rd_idx + 1'b1;
        if (last_rd) pass_cnt <= pass_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      res_q <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= state_d == DONE;
      if (hit) res_q <= '{dt_level, dt_path, 1'b0};
      else if (abort) res_q <= '{'0, '0, 1'b1};
    end
  end

  assign res_level = res_q.level;
  assign res_path = res_q.path;
  assign res_err = res_q.err;
endmodule

// File: tb/tb_dtree_feeder.sv
// Bench for dtree_feeder: vector table with a beat scoreboard,
// plus drop-count saturation and mid-stream reset sequences.
module tb_dtree_feeder;
  localparam int F = 3;
  localparam int W = 10;
  localparam int MP = 4;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] in_sample;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] dt_sample;
  logic dt_valid;
  logic dt_ready;
  logic [1:0] dt_level;
  logic [1:0] dt_path;
  logic dt_out_valid;
  logic [1:0] res_level;
  logic [1:0] res_path;
  logic res_valid;
  logic res_err;
  logic [7:0] drop_count;

  dtree_feeder #(
    .FEATURES(F),
    .IN_WIDTH(W),
    .MAX_PASSES(MP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_sample(in_sample),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dt_sample(dt_sample),
    .dt_valid(dt_valid),
    .dt_ready(dt_ready),
    .dt_level(dt_level),
    .dt_path(dt_path),
    .dt_out_valid(dt_out_valid),
    .res_level(res_level),
    .res_path(res_path),
    .res_valid(res_valid),
    .res_err(res_err),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s0;
    int s1;
    int s2;
    int ans;
    int lvl;
    int pth;
    int err;
    logic [31:0] pat;
    int lat;
  } vec_t;

  vec_t tbl [6];
  int errors = 0;
  int checks = 0;
  int exp_q [$];
  int ans_n = 0;
  int cnt_m = 0;
  bit prev_stall = 1'b0;
  int held = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // dtree model: answers once, right after its ans_n-th accepted beat
  always @(posedge clk) begin
    if (!reset || in_ready) begin
      cnt_m <= 0;
      dt_out_valid <= 1'b0;
    end else begin
      dt_out_valid <= !dt_out_valid && ans_n != 0 &&
        (cnt_m + int'(dt_valid && dt_ready)) == ans_n;
      cnt_m <= cnt_m + int'(dt_valid && dt_ready);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("dt_hold_valid", int'(dt_valid), 1);
        chk("dt_hold_sample", int'(dt_sample), held);
      end
      if (dt_valid && dt_ready) begin
        if (exp_q.size() == 0)
          chk("dt_extra_beat", exp_q.size(), 1);
        else
          chk("dt_sample", int'(dt_sample), exp_q.pop_front());
      end
      prev_stall = dt_valid && !dt_ready;
      held = int'(dt_sample);
    end
  end

  task automatic load3(input int a, input int b, input int c,
                       input bit keep_valid);
    int s [3];
    s = '{a, b, c};
    for (int i = 0; i < F; i++) begin
      in_valid = 1'b1;
      in_sample = W'(s[i]);
      chk("in_ready_load", int'(in_ready), 1);
      @(posedge clk);
      #1;
    end
    in_valid = keep_valid;
  endtask

  task automatic run_vec(input vec_t v);
    int s [3];
    int nvis;
    int lat;
    int el;
    int ep;
    s = '{v.s0, v.s1, v.s2};
    ans_n = v.ans;
    dt_level = 2'(v.lvl);
    dt_path = 2'(v.pth);
    dt_ready = 1'b0;
    el = v.err != 0 ? 0 : v.lvl;
    ep = v.err != 0 ? 0 : v.pth;
    if (v.ans == 0) nvis = F * MP;
    else if (v.ans % F == 0) nvis = v.ans;
    else nvis = v.ans + 1;
    for (int k = 0; k < nvis; k++)
      exp_q.push_back(s[k % F]);
    load3(v.s0, v.s1, v.s2, 1'b0);
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      dt_ready = (c <= 32) ? v.pat[c-1] : 1'b1;
      @(negedge clk);
      if (res_valid) lat = c;
      @(posedge clk);
      #1;
    end
    chk("latency", lat, v.lat);
    chk("in_ready_after_done", int'(in_ready), 1);
    chk("res_valid_pulse", int'(res_valid), 0);
    chk("res_err", int'(res_err), v.err);
    chk("res_level", int'(res_level), el);
    chk("res_path", int'(res_path), ep);
    chk("dt_beats_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{5, 17, 1023, 3, 2, 1, 0, 32'hFFFF_FFFF, 5};
    tbl[1] = '{5, 17, 1023, 3, 1, 3, 0, 32'hFFFF_FFE1, 9};
    tbl[2] = '{7, 8, 9, 0, 3, 3, 1, 32'hFFFF_FFFF, 16};
    tbl[3] = '{100, 200, 300, 5, 3, 2, 0, 32'hFFFF_FFFF, 8};
    tbl[4] = '{1, 0, 512, 1, 0, 1, 0, 32'hFFFF_FFFF, 3};
    tbl[5] = '{11, 22, 33, 6, 1, 0, 0, 32'hFFFF_FFFF, 9};

    reset = 1'b0;
    in_valid = 1'b0;
    in_sample = '0;
    dt_ready = 1'b0;
    dt_level = '0;
    dt_path = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_dt_valid", int'(dt_valid), 0);
    chk("rst_dt_sample", int'(dt_sample), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_err", int'(res_err), 0);
    chk("rst_res_level", int'(res_level), 0);
    chk("rst_res_path", int'(res_path), 0);
    chk("rst_drop", int'(drop_count), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_release", int'(in_ready), 1);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    ans_n = 0;
    dt_ready = 1'b0;
    load3(40, 41, 42, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("drop_10", int'(drop_count), 10);
    repeat (290) @(posedge clk);
    #1;
    chk("drop_sat", int'(drop_count), 255);

    in_valid = 1'b0;
    exp_q.push_back(40);
    exp_q.push_back(41);
    dt_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    dt_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_dt_valid", int'(dt_valid), 0);
    chk("mid_dt_sample", int'(dt_sample), 0);
    chk("mid_in_ready", int'(in_ready), 0);
    chk("mid_res_valid", int'(res_valid), 0);
    chk("mid_res_err", int'(res_err), 0);
    chk("mid_res_level", int'(res_level), 0);
    chk("mid_res_path", int'(res_path), 0);
    chk("mid_drop", int'(drop_count), 0);
    chk("mid_beats_left", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_in_ready_release", int'(in_ready), 1);
    dt_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("mid_no_stream", int'(dt_valid), 0);
    end
    run_vec(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dtree_feeder.md
DTREE_FEEDER -- requirements
Module: dtree_feeder

Interface
REQ-001 SHALL have parameter FEATURES, default 3, meaning samples per feature vector.
REQ-002 SHALL have parameter IN_WIDTH, default 10, meaning sample width in bits.
REQ-003 SHALL have parameter MAX_PASSES, default 4, meaning the maximum vector presentations per classification before abort.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-006 SHALL have port in_sample, input, IN_WIDTH, the raw feature sample from upstream.
REQ-007 SHALL have port in_valid, input, 1, meaning in_sample is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts in_sample this cycle.
REQ-009 SHALL have port dt_sample, output, IN_WIDTH, the feature sample sent to dtree.
REQ-010 SHALL have port dt_valid, output, 1, meaning dt_sample is valid.
REQ-011 SHALL have port dt_ready, input, 1, the dtree ready signal.
REQ-012 SHALL have ports dt_level (input, 2), dt_path (input, 2) and dt_out_valid (input, 1), which carry the dtree result.
REQ-013 SHALL have ports res_level (output, 2), res_path (output, 2), res_valid (output, 1) and res_err (output, 1), which carry the registered result.
REQ-014 SHALL have port drop_count, output, 8, a saturating count of upstream samples offered while in_ready=0.

Function
REQ-015 SHALL implement the states LOAD, STREAM, GAP and DONE.
REQ-016 In LOAD: in_ready=1 and dt_valid=0; each in_valid&in_ready beat writes buf[wr_idx], and wr_idx increments.
REQ-017 LOAD SHALL move to STREAM on the beat that writes index FEATURES-1, with wr_idx reset to 0 and pass_cnt reset to 0.
REQ-018 In STREAM: dt_valid=1 and dt_sample=buf[rd_idx]; both SHALL be held stable until dt_valid&dt_ready.
REQ-019 Each STREAM transfer SHALL increment rd_idx; after the transfer of index FEATURES-1, rd_idx=0, pass_cnt increments and the state moves to GAP.
REQ-020 GAP SHALL last exactly 1 cycle with dt_valid=0, then return to STREAM to replay the same vector.
REQ-021 In STREAM or GAP, if dt_out_valid=1, the block SHALL register dt_level/dt_path into res_level/res_path, set res_err=0, and move to DONE; a concurrent dt beat counts as transferred but is ignored.
REQ-022 If pass_cnt reaches MAX_PASSES with no dt_out_valid, the block SHALL move to DONE with res_err=1, res_level=0 and res_path=0.
REQ-023 DONE SHALL last 1 cycle with res_valid=1, then move to LOAD; res_valid is a single-cycle pulse, and res_level/res_path hold until the next result.
REQ-024 dt_out_valid SHALL be ignored in LOAD and DONE.
REQ-025 in_ready SHALL be 1 only in LOAD; each in_valid=1 with in_ready=0 SHALL increment drop_count, which saturates at 255.
REQ-026 in_ready is registered from state, so the buffer SHALL NOT be overwritten while streaming.
REQ-027 Latency from the last LOAD beat to the first dt_valid SHALL be 1 cycle.

Reset
REQ-028 While reset=0 at a clock edge, the block SHALL enter LOAD and clear wr_idx, rd_idx, pass_cnt and drop_count.
REQ-029 While reset=0, outputs SHALL be: dt_valid=0, dt_sample=0, in_ready=0, res_valid=0, res_err=0, res_level=0, res_path=0.
REQ-030 A reset in any state SHALL abandon the vector in flight; buffer contents need not be cleared.
REQ-031 in_ready SHALL go to 1 on the first cycle after reset=1.

Structure
REQ-032 Package dtree_pkg SHALL hold IN_WIDTH, FEATURES, the state enumeration, and the level/path widths (2) shared with dtree.
REQ-033 Sub-module dtree_feature_buf SHALL implement the FEATURES x IN_WIDTH register file with one write port and one read port.
REQ-034 Index and pass counters SHALL be $clog2-sized, with widths of at least 1.

Verification
REQ-035 Load 5, 17, 1023 with dt_ready=1 and dtree answering after 3 beats -> dt_sample is 5, 17, 1023, then res_valid pulses once with res_level/res_path equal to the dtree values and res_err=0.
REQ-036 dt_ready=0 for 4 cycles while dt_sample=17 -> dt_sample holds 17 and dt_valid stays 1 throughout, with no skipped or duplicated beats.
REQ-037 No dt_out_valid -> exactly 4 passes of 3 beats, each separated by a 1-cycle gap, then res_valid=1 with res_err=1.
REQ-038 dt_out_valid in the GAP cycle after pass 1 -> no second pass starts, DONE follows, then in_ready=1.
REQ-039 in_valid held high through 300 non-LOAD cycles -> drop_count=255 (saturated).
REQ-040 reset=0 asserted mid-STREAM after beat 2 -> all outputs take their reset values next cycle, and a fresh 3-sample load is required before dt_valid rises again.
